// File: rtl/alu_resp_checker_if.sv
// alu_resp_checker_if
//  Vector handshake between the stimulus side and the response checker.
//  One vector moves when in_valid and in_ready are both high on a rising edge.
//  Signals:
//   in_valid  master->slave  vector present on a/b/s/dut_out
//   in_ready  slave->master  checker accepts the vector this cycle
//   a, b      master->slave  operands as applied to the circuit
//   s         master->slave  2-bit operation select
//   dut_out   master->slave  observed circuit output
interface alu_resp_checker_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       s;
  logic [WIDTH-1:0] dut_out;

  modport master (
    output in_valid,
    output a,
    output b,
    output s,
    output dut_out,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  s,
    input  dut_out,
    output in_ready
  );
endinterface

// File: rtl/alu_resp_checker.sv
// alu_resp_checker
//  Response checker for the 16-bit add/sub/and/or circuit. Each accepted vector
//  is compared with a golden result. Pass and fail counts are kept, and the first
//  mismatching vector of a run is captured. done is raised after NUM_VEC vectors.
//  Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                begins a clean run (honoured in IDLE or DONE only)
//   vin (slave)          in_valid/in_ready handshake, a, b, s, dut_out
//   busy                 run in progress (RUN or DRAIN)
//   done                 run complete, held until start or rst
//   pass_cnt, fail_cnt   saturating match/mismatch counters
//   err                  sticky first-mismatch flag
//   ff_a, ff_b, ff_s     operands and select of the first mismatch
//   ff_got, ff_exp       observed and expected value of the first mismatch
module alu_resp_checker #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 16,
  parameter int NUM_VEC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  alu_resp_checker_if.slave   vin,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                err,
  output logic [WIDTH-1:0]    ff_a,
  output logic [WIDTH-1:0]    ff_b,
  output logic [1:0]          ff_s,
  output logic [WIDTH-1:0]    ff_got,
  output logic [WIDTH-1:0]    ff_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_VEC  = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W:0]   TOTAL_VEC = (CNT_W + 1)'(NUM_VEC);

  // Golden model; carry and borrow fall off the top (mod 2^WIDTH).
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] op_a,
                                               input logic [WIDTH-1:0] op_b,
                                               input logic [1:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = op_a + op_b;
      2'b01:   r = op_a - op_b;
      2'b10:   r = op_a & op_b;
      default: r = op_a | op_b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  logic [1:0]       s_p1_q, s_p1_d;
  logic [WIDTH-1:0] got_p1_q, got_p1_d;
  logic [WIDTH-1:0] exp_p1_q, exp_p1_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic [1:0]       ff_s_q, ff_s_d;
  logic [WIDTH-1:0] ff_got_q, ff_got_d;
  logic [WIDTH-1:0] ff_exp_q, ff_exp_d;

  logic             xfer;
  logic             clear;
  logic [CNT_W:0]   total;

  assign total = {1'b0, pass_cnt_q} + {1'b0, fail_cnt_q};

  // Control FSM
  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    clear        = 1'b0;
    vin.in_ready = (state_q == RUN);
    busy         = (state_q == RUN) || (state_q == DRAIN);
    done         = (state_q == DONE);
    xfer         = vin.in_valid && (state_q == RUN);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_q == LAST_VEC) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // S1 must be empty and its last result already folded into the counts.
        if (!vld_p1_q && (total == TOTAL_VEC)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S1: capture vector and golden value
  always_comb begin
    vld_p1_d = xfer;
    a_p1_d   = vin.a;
    b_p1_d   = vin.b;
    s_p1_d   = vin.s;
    got_p1_d = vin.dut_out;
    exp_p1_d = golden(vin.a, vin.b, vin.s);
  end

  // S2: compare, count, capture first mismatch
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_s_d     = ff_s_q;
    ff_got_d   = ff_got_q;
    ff_exp_d   = ff_exp_q;
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      ff_a_d     = '0;
      ff_b_d     = '0;
      ff_s_d     = '0;
      ff_got_d   = '0;
      ff_exp_d   = '0;
    end else if (vld_p1_q) begin
      if (got_p1_q == exp_p1_q) begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        if (!err_q) begin
          err_d    = 1'b1;
          ff_a_d   = a_p1_q;
          ff_b_d   = b_p1_q;
          ff_s_d   = s_p1_q;
          ff_got_d = got_p1_q;
          ff_exp_d = exp_p1_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      vld_p1_q   <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_s_q     <= '0;
      ff_got_q   <= '0;
      ff_exp_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      vld_p1_q   <= vld_p1_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_s_q     <= ff_s_d;
      ff_got_q   <= ff_got_d;
      ff_exp_q   <= ff_exp_d;
    end
  end

  // S1 data is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    a_p1_q   <= a_p1_d;
    b_p1_q   <= b_p1_d;
    s_p1_q   <= s_p1_d;
    got_p1_q <= got_p1_d;
    exp_p1_q <= exp_p1_d;
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err      = err_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_s     = ff_s_q;
  assign ff_got   = ff_got_q;
  assign ff_exp   = ff_exp_q;

endmodule
